input_conditioner: RTL and testbench

Front-end stage for the exercise-1 state machine: takes the two raw asynchronous board inputs and produces the clean, clock-aligned `I` and `S` signals the state machine samples. Each channel has a two-flop synchronizer and a counter-based debouncer. `I` is delivered as a debounced level. `S` is delivered as a single-cycle pulse per accepted press, so a held button causes exactly one state-machine step.

---
 rtl/input_conditioner.sv | 56 +++++
 tb/tb_input_conditioner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - two-flop synchronizer and counter debouncer for the I and S inputs
// S is reduced to a one-cycle pulse per accepted press; I and s_held are debounced levels.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic raw_s,
    output logic I,
    output logic S,
    output logic s_held
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Index 0 is channel I, index 1 is channel S.
    logic [1:0]       sync0;
    logic [1:0]       sync1;
    logic [1:0]       deb;
    logic [CNT_W-1:0] cnt [2];
    logic             s_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0   <= '0;
            sync1   <= '0;
            deb     <= '0;
            s_pulse <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            sync0 <= {raw_s, raw_i};
            sync1 <= sync0;
            for (int c = 0; c < 2; c++) begin
                if (sync1[c] == deb[c]) begin
                    cnt[c] <= '0;
                end else if (cnt[c] == LAST) begin
                    deb[c] <= sync1[c];
                    cnt[c] <= '0;
                end else begin
                    cnt[c] <= cnt[c] + 1'b1;
                end
            end
            // Fires on the same edge that deb_s is accepted 0->1.
            s_pulse <= sync1[1] && !deb[1] && (cnt[1] == LAST);
        end
    end

    assign I      = deb[0];
    assign s_held = deb[1];
    assign S      = s_pulse;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - randomized and directed bench for input_conditioner
// Reference model: an output flips once the last N debouncer samples all disagree with it.
`timescale 1ns/100ps
module tb_input_conditioner;

    localparam int N    = 4;
    localparam int HMAX = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_i = 1'b0;
    logic raw_s = 1'b0;
    logic I;
    logic S;
    logic s_held;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int s_pulses = 0;
    bit valid = 1'b0;

    // Model state
    bit hist [2][HMAX];
    bit dh   [2][HMAX];
    int n = 0;
    bit m_deb [2];
    bit m_s = 1'b0;

    input_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .raw_i(raw_i), .raw_s(raw_s),
        .I(I), .S(S), .s_held(s_held)
    );

    always #1 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Debouncer input at sample n is the raw value two samples earlier since reset.
    always @(posedge clk) begin
        bit raw [2];
        bit d;
        bit flip;
        cyc++;
        if (rst) begin
            n = 0;
            m_deb[0] = 1'b0;
            m_deb[1] = 1'b0;
            m_s = 1'b0;
            valid = 1'b1;
        end else begin
            raw[0] = raw_i;
            raw[1] = raw_s;
            m_s = 1'b0;
            for (int c = 0; c < 2; c++) begin
                d = (n >= 2) ? hist[c][n-2] : 1'b0;
                hist[c][n] = raw[c];
                dh[c][n] = d;
                flip = (n >= N - 1);
                if (flip) begin
                    for (int j = 0; j < N; j++) begin
                        if (dh[c][n-j] == m_deb[c]) flip = 1'b0;
                    end
                end
                if (flip) begin
                    if (c == 1 && !m_deb[1]) m_s = 1'b1;
                    m_deb[c] = !m_deb[c];
                end
            end
            if (n < HMAX - 1) n++;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            check("I", {31'd0, I}, {31'd0, m_deb[0]});
            check("s_held", {31'd0, s_held}, {31'd0, m_deb[1]});
            check("S", {31'd0, S}, {31'd0, m_s});
            if (S === 1'b1) s_pulses++;
        end
    end

    task automatic hold(input bit ri, input bit rs, input int cycles);
        raw_i = ri;
        raw_s = rs;
        repeat (cycles) begin
            @(posedge clk);
            #0.2;
        end
    endtask

    // Called just after the edge preceding E0; measures edges from E0 to I rising.
    task automatic measure_i(input string tag);
        int e0;
        bit seen;
        seen = 1'b0;
        @(posedge clk);
        #0.5;
        e0 = cyc;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (I === 1'b1) seen = 1'b1;
        end
        check(tag, cyc - e0, 5);
        @(posedge clk);
        #0.2;
    endtask

    initial begin
        int p0;
        raw_i = 1'b1;
        raw_s = 1'b1;
        rst = 1'b1;
        @(posedge clk); #0.2;
        @(posedge clk); #0.2;
        check("reset_I", {31'd0, I}, 0);
        check("reset_S", {31'd0, S}, 0);
        p0 = s_pulses;
        rst = 1'b0;
        measure_i("lat_reset_high");
        hold(1, 1, 10);
        check("reset_high_pulses", s_pulses - p0, 1);

        // Clean press and hold
        hold(0, 0, 12);
        p0 = s_pulses;
        hold(0, 1, 20);
        hold(0, 0, 12);
        check("press_pulses", s_pulses - p0, 1);

        // Glitch rejection
        p0 = s_pulses;
        hold(0, 1, 3);
        hold(0, 0, 12);
        check("glitch3_pulses", s_pulses - p0, 0);
        p0 = s_pulses;
        hold(0, 1, 4);
        hold(0, 0, 12);
        check("glitch4_pulses", s_pulses - p0, 1);

        // Bounce on I
        hold(1, 0, 1);
        hold(0, 0, 1);
        hold(1, 0, 1);
        hold(0, 0, 1);
        raw_i = 1'b1;
        measure_i("lat_bounce");
        hold(1, 0, 5);
        hold(0, 0, 12);

        // Reset mid-count
        hold(1, 0, 3);
        rst = 1'b1;
        hold(1, 0, 1);
        rst = 1'b0;
        measure_i("lat_reset_mid");
        hold(0, 0, 12);

        // Simultaneous channels
        p0 = s_pulses;
        hold(1, 1, 20);
        check("simul_pulses", s_pulses - p0, 1);
        hold(0, 0, 12);

        // Random segments with occasional reset
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                hold(raw_i, raw_s, 1);
                rst = 1'b0;
            end
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end
        hold(0, 0, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
